shift_add_multiplier: RTL

- Sequential unsigned WIDTH x WIDTH multiplier controller.
- Sits directly upstream of the team's ripple four_bit_full_adder. It drives the adder's a/b/c0 inputs and consumes its s/c4 outputs combinationally in the same cycle.
- Adds one partial product per clock and presents a 2*WIDTH product with a start/busy/done handshake.
- Top-level integration wires add_a->a, add_b->b, add_c0->c0, s->add_s, c4->add_c4.

---
 rtl/shift_add_multiplier.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier controller.
// Drives an external ripple adder each RUN cycle and shifts its result into {ACC,Q}.
module shift_add_multiplier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c0,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_c4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PW = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    step;
  logic             last_step;

  // C sits just above the shifted window, so it refills from itself (always 0);
  // the adder carry lands in the ACC MSB instead of being dropped.
  assign step      = PW'({c, add_c4, add_s, q} >> 1);
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_c0    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy  = 1'b1;
        add_a = acc;
        add_b = q[0] ? m : '0;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // product is only written on the final RUN edge, so the old result stays visible meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= mcand;
            q   <= mplier;
            acc <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          {c, acc, q} <= step;
          cnt         <= last_step ? '0 : cnt + 1'b1;
          if (last_step) product <= step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
